// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue
//   FIFO between fetch and decode. Each entry carries the {pc, inst, pc4} triple
//   produced by fetch, so decode can stall without fetch dropping instructions.
//   The head entry is always presented on out_* (first-word-fall-through).
//   A redirect (flush) empties the queue on the next edge.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   flush                discard all entries; wins over push and pop
//   in_valid/in_ready    fetch-side handshake, with in_pc/in_inst/in_pc4
//   out_valid/out_ready  decode-side handshake, with out_pc/out_inst/out_pc4
//   count                number of occupied entries (0..DEPTH)
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    input  logic [XLEN-1:0]            in_pc4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [XLEN-1:0]            out_pc4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    // Presented when empty so decode sees a harmless addi x0,x0,0.
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // in_ready depends only on occupancy: no bypass when full and being drained.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

    // Storage is intentionally not reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, pc4: in_pc4};
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits;
    // cnt tells full from empty when the pointers are equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign out_pc   = out_valid ? head.pc   : '0;
    assign out_inst = out_valid ? head.inst : NOP;
    assign out_pc4  = out_valid ? head.pc4  : '0;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc, in_inst, in_pc4;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc, out_inst, out_pc4;
    logic [CW-1:0]   count;

    if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_pc4(out_pc4),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } ent_t;

    // Reference model: a plain bounded queue.
    ent_t            mq[$];
    logic [XLEN-1:0] model_pops[$];
    logic [XLEN-1:0] dut_pops[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge, using the inputs held since the last edge.
    always @(posedge clk) begin
        if (rst_n) begin
            bit m_push, m_pop;
            m_push = in_valid && (mq.size() != DEPTH);
            m_pop  = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) begin
                    model_pops.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (m_push) mq.push_back('{pc: in_pc, inst: in_inst, pc4: in_pc4});
            end
        end
    end

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic            e_valid;
            logic [XLEN-1:0] e_pc, e_inst, e_pc4;
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc   : '0;
            e_inst  = e_valid ? mq[0].inst : 32'h0000_0013;
            e_pc4   = e_valid ? mq[0].pc4  : '0;
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
            chk("count",     64'(count),     64'(mq.size()));
            chk("out_pc",    64'(out_pc),    64'(e_pc));
            chk("out_inst",  64'(out_inst),  64'(e_inst));
            chk("out_pc4",   64'(out_pc4),   64'(e_pc4));
            if (out_valid && out_ready && !flush) dut_pops.push_back(out_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = pc ^ 32'h0000_0093;
        in_pc4   = pc + 32'd4;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_pc4 = '0;

        // 1: reset state, then idle
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_inst",  64'(out_inst),  64'h13);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // 2: single pass
        in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h0050_0093; in_pc4 = 32'h4;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_out_pc",    64'(out_pc),    64'h0);
        chk("t2_out_inst",  64'(out_inst),  64'h0050_0093);
        tick();
        chk("t2_count",     64'(count),     64'd0);
        chk("t2_out_valid2", 64'(out_valid), 64'd0);

        // 3: fill, stall, drain in order
        out_ready = 1'b0;
        dut_pops.delete(); model_pops.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4*i));
            tick();
        end
        chk("t3_full_count", 64'(count), 64'd4);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h10);
        repeat (2) tick();
        chk("t3_held_count", 64'(count), 64'd4);
        chk("t3_held_pc", 64'(out_pc), 64'h0);
        out_ready = 1'b1;
        tick();
        chk("t3_pop_full_count", 64'(count), 64'd3);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t3_npops", 64'(dut_pops.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            logic [XLEN-1:0] a, m;
            a = (i < dut_pops.size())   ? dut_pops[i]   : 32'hdead_beef;
            m = (i < model_pops.size()) ? model_pops[i] : 32'hdead_beef;
            chk("t3_pop_order", 64'(a), 64'(4*i));
            chk("t3_model_order", 64'(m), 64'(4*i));
        end

        // 4: steady push/pop across pointer wrap
        drive(1'b1, 32'h18); tick();
        drive(1'b1, 32'h1C); tick();
        dut_pops.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h20 + 32'(4*k));
            tick();
            chk("t4_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("t4_npops", 64'(dut_pops.size()), 64'd12);
        for (int i = 0; i < dut_pops.size(); i++)
            chk("t4_seq", 64'(dut_pops[i]), 64'(32'h18 + 32'(4*i)));

        // 5: flush with concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h50 + 32'(4*i));
            tick();
        end
        chk("t5_pre_count", 64'(count), 64'd3);
        flush = 1'b1; drive(1'b1, 32'h100); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h200);
        tick();
        in_valid = 1'b0;
        chk("t5_next_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // 6: asynchronous reset between edges
        drive(1'b1, 32'h300); tick();
        drive(1'b1, 32'h304); tick();
        in_valid = 1'b0;
        chk("t6_pre_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 99) < 60, $urandom);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 4);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        chk("final_drained", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
